// File: rtl/mux_pkg.sv
// Shared mode constants and index-width helper for the arb_mux slice.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Never return 0 so a select bus always has at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority finder: first set REQ bit scanning PTR, PTR+1, ... mod N.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = idx_width(N)
) (
    input  logic [N-1:0]  REQ,
    input  logic [SW-1:0] PTR,
    output logic          GNT_VALID,
    output logic [SW-1:0] GNT_IDX
);

    logic [SW-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        GNT_VALID = 1'b0;
        GNT_IDX   = '0;
        idx       = '0;
        // Scan from the far end so the candidate closest to PTR is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            idx = SW'((int'(PTR) + k) % N);
            if (REQ[idx]) begin
                GNT_VALID = 1'b1;
                GNT_IDX   = idx;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating mux with fixed-select or round-robin grant and a one-deep
// registered output stage with valid/ready back-pressure.
module arb_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SW    = idx_width(N)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N*WIDTH-1:0] IN,
    input  logic [N-1:0]       VALID,
    output logic [N-1:0]       READY,
    input  logic               RR,
    input  logic [SW-1:0]      S,
    output logic [WIDTH-1:0]   Q,
    output logic               Q_VALID,
    output logic [SW-1:0]      Q_ID,
    input  logic               Q_READY
);

    logic             ld;
    logic             rr_valid;
    logic [SW-1:0]    rr_idx;
    logic             fix_valid;
    logic             gnt_valid;
    logic [SW-1:0]    gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [SW-1:0]    ptr;

    rr_pick #(.N(N)) u_pick (
        .REQ       (VALID),
        .PTR       (ptr),
        .GNT_VALID (rr_valid),
        .GNT_IDX   (rr_idx)
    );

    // The output register may load whenever it is empty or being drained this cycle.
    assign ld = !Q_VALID || Q_READY;

    // Fixed mode: an out-of-range S matches no channel and therefore grants nothing.
    always_comb begin
        fix_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (S == SW'(i) && VALID[i])
                fix_valid = 1'b1;
        end
        gnt_valid = (RR == MODE_RR) ? rr_valid : fix_valid;
        gnt_idx   = (RR == MODE_RR) ? rr_idx   : S;
    end

    always_comb begin
        READY    = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) begin
                READY[i] = ld && gnt_valid && !RST;
                gnt_data = IN[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q       <= '0;
            Q_VALID <= 1'b0;
            Q_ID    <= '0;
            ptr     <= '0;
        end else if (ld) begin
            if (gnt_valid) begin
                Q       <= gnt_data;
                Q_ID    <= gnt_idx;
                Q_VALID <= 1'b1;
                ptr     <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                Q_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: stimulus pushes expected items, a monitor pops them on accepted outputs.
module tb_arb_mux;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } item_t;

    logic        CLK;
    logic        RST;
    logic [127:0] IN;
    logic [3:0]  VALID;
    logic [3:0]  READY;
    logic        RR;
    logic [1:0]  S;
    logic [31:0] Q;
    logic        Q_VALID;
    logic [1:0]  Q_ID;
    logic        Q_READY;

    logic [23:0] in3;
    logic [2:0]  valid3;
    logic [2:0]  ready3;
    logic        rr3;
    logic [1:0]  s3;
    logic [7:0]  q3;
    logic        q_valid3;
    logic [1:0]  q_id3;
    logic        q_ready3;

    int checks   = 0;
    int failures = 0;
    item_t sb_q[$];
    logic [31:0] data_tbl [4];

    arb_mux #(.WIDTH(32), .N(4)) u_dut (
        .CLK(CLK), .RST(RST), .IN(IN), .VALID(VALID), .READY(READY), .RR(RR), .S(S),
        .Q(Q), .Q_VALID(Q_VALID), .Q_ID(Q_ID), .Q_READY(Q_READY)
    );

    arb_mux #(.WIDTH(8), .N(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .IN(in3), .VALID(valid3), .READY(ready3), .RR(rr3), .S(s3),
        .Q(q3), .Q_VALID(q_valid3), .Q_ID(q_id3), .Q_READY(q_ready3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs are already set; check READY, record the expected item, then cross one edge.
    task automatic step(input string name, input logic [3:0] exp_ready, input bit do_push, input int id);
        item_t it;
        #1;
        check(name, 64'(READY), 64'(exp_ready));
        if (do_push) begin
            it.id   = 2'(id);
            it.data = data_tbl[id];
            sb_q.push_back(it);
        end
        @(posedge CLK);
        #1;
    endtask

    // Monitor: an item is consumed on any edge where Q_VALID and Q_READY are both high.
    initial begin
        item_t exp_it;
        forever begin
            @(negedge CLK);
            if (Q_VALID && Q_READY) begin
                check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    exp_it = sb_q.pop_front();
                    check("sb_q_id", 64'(Q_ID), 64'(exp_it.id));
                    check("sb_q_data", 64'(Q), 64'(exp_it.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        data_tbl[0] = 32'h5555_5555;
        data_tbl[1] = 32'hAAAA_AAAA;
        data_tbl[2] = 32'h0000_0000;
        data_tbl[3] = 32'hFFFF_FFFF;
        IN       = {data_tbl[3], data_tbl[2], data_tbl[1], data_tbl[0]};
        in3      = {8'h33, 8'h22, 8'h11};
        valid3   = 3'b000;
        rr3      = 1'b0;
        s3       = 2'd0;
        q_ready3 = 1'b1;

        // Reset held for two edges with every channel offering data.
        RST = 1'b1; VALID = 4'b1111; RR = 1'b1; S = 2'd0; Q_READY = 1'b1;
        #1;
        check("rst_ready", 64'(READY), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready_held", 64'(READY), 64'd0);
        check("rst_q", 64'(Q), 64'd0);
        check("rst_q_valid", 64'(Q_VALID), 64'd0);
        check("rst_q_id", 64'(Q_ID), 64'd0);

        // Round-robin over all four channels, wrapping back to 0.
        RST = 1'b0;
        step("rr_ready0", 4'b0001, 1, 0);
        step("rr_ready1", 4'b0010, 1, 1);
        step("rr_ready2", 4'b0100, 1, 2);
        step("rr_ready3", 4'b1000, 1, 3);
        step("rr_wrap",   4'b0001, 1, 0);

        // Fixed select stepping through every channel.
        RR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            S = 2'(i);
            step("fix_ready", 4'(1 << i), 1, i);
        end

        // Sparse round-robin: only channels 1 and 3 offer data.
        RR = 1'b1; VALID = 4'b1010;
        step("sparse_ready_a", 4'b0010, 1, 1);
        step("sparse_ready_b", 4'b1000, 1, 3);
        step("sparse_ready_c", 4'b0010, 1, 1);

        // Back-pressure: output must hold while the consumer stalls.
        VALID = 4'b1111; Q_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("bp_ready", 4'b0000, 0, 0);
            check("bp_q", 64'(Q), 64'h0000_0000_AAAA_AAAA);
            check("bp_q_id", 64'(Q_ID), 64'd1);
            check("bp_q_valid", 64'(Q_VALID), 64'd1);
        end
        Q_READY = 1'b1;
        step("bp_release", 4'b0100, 1, 2);
        check("bp_no_bubble", 64'(Q_VALID), 64'd1);
        step("bp_next", 4'b1000, 1, 3);

        // Load with no grant: valid drops, data and id hold.
        VALID = 4'b0000;
        step("idle_ready", 4'b0000, 0, 0);
        check("idle_q_valid", 64'(Q_VALID), 64'd0);
        check("idle_q_hold", 64'(Q), 64'h0000_0000_FFFF_FFFF);
        check("idle_q_id_hold", 64'(Q_ID), 64'd3);

        // Mid-stream reset discards the held item and rewinds the pointer.
        VALID = 4'b1111;
        step("pre_rst_ready", 4'b0001, 1, 0);
        RST = 1'b1; Q_READY = 1'b0;
        #1;
        check("mid_rst_ready", 64'(READY), 64'd0);
        sb_q.delete();
        @(posedge CLK);
        #1;
        check("mid_rst_q_valid", 64'(Q_VALID), 64'd0);
        check("mid_rst_q", 64'(Q), 64'd0);
        check("mid_rst_q_id", 64'(Q_ID), 64'd0);
        RST = 1'b0; Q_READY = 1'b1;
        step("post_rst_ready", 4'b0001, 1, 0);
        VALID = 4'b0000;
        step("drain_ready", 4'b0000, 0, 0);

        // Three-channel instance: out-of-range select grants nothing.
        valid3 = 3'b111; rr3 = 1'b0; s3 = 2'd0;
        #1;
        check("n3_ready_s0", 64'(ready3), 64'b001);
        @(posedge CLK); #1;
        check("n3_q_s0", 64'(q3), 64'h11);
        check("n3_q_valid_s0", 64'(q_valid3), 64'd1);
        check("n3_q_id_s0", 64'(q_id3), 64'd0);
        s3 = 2'd3;
        #1;
        check("n3_ready_s3", 64'(ready3), 64'b000);
        @(posedge CLK); #1;
        check("n3_q_valid_s3", 64'(q_valid3), 64'd0);
        check("n3_q_hold_s3", 64'(q3), 64'h11);
        s3 = 2'd2;
        #1;
        check("n3_ready_s2", 64'(ready3), 64'b100);
        @(posedge CLK); #1;
        check("n3_q_s2", 64'(q3), 64'h33);
        check("n3_q_id_s2", 64'(q_id3), 64'd2);
        RST = 1'b1;
        #1;
        check("n3_rst_ready", 64'(ready3), 64'b000);
        @(posedge CLK); #1;
        check("n3_rst_q_valid", 64'(q_valid3), 64'd0);
        check("n3_rst_q", 64'(q3), 64'd0);
        RST = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
